// File: rtl/scx_arb.sv
// Two-requester arbiter in front of a single SCx slave core.
// Round-robin on collision, LOCK-held bursts, wait timeout with fault.
module scx_arb #(
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        R0_REQ,
    input  logic        R0_LOCK,
    input  logic        R0_WT,
    input  logic [3:0]  R0_BE,
    input  logic [31:0] R0_ADDR,
    input  logic [38:0] R0_WDT,
    output logic        R0_nWAIT,
    output logic        R0_FAULT,
    output logic        R0_TimeOut,
    output logic [38:0] R0_RDT,
    input  logic        R1_REQ,
    input  logic        R1_LOCK,
    input  logic        R1_WT,
    input  logic [3:0]  R1_BE,
    input  logic [31:0] R1_ADDR,
    input  logic [38:0] R1_WDT,
    output logic        R1_nWAIT,
    output logic        R1_FAULT,
    output logic        R1_TimeOut,
    output logic [38:0] R1_RDT,
    output logic        SCx_REQ,
    output logic        SCx_WT,
    output logic [3:0]  SCx_BE,
    output logic [31:0] SCx_ADDR,
    output logic [38:0] SCx_WDT,
    input  logic        SCx_nWAIT,
    input  logic        SCx_FAULT,
    input  logic [38:0] SCx_RDT,
    output logic [1:0]  GNT
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    localparam logic [15:0] TO_W  = TO_CYCLES[15:0];
    localparam logic [15:0] TO_M1 = TO_W - 16'd1;

    state_t      r_state;
    state_t      w_nxt;
    logic        r_last;
    logic [15:0] r_wcnt;
    logic        w_to;
    logic        w_g0;
    logic        w_g1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_wcnt  <= 16'd0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) begin
                if (w_nxt == ST_G0)
                    r_last <= 1'b0;
                else if (w_nxt == ST_G1)
                    r_last <= 1'b1;
            end
            if (w_nxt != r_state || SCx_nWAIT)
                r_wcnt <= 16'd0;
            else if (r_state != ST_IDLE && r_wcnt != TO_W)
                r_wcnt <= r_wcnt + 16'd1;
        end
    end

    // Timeout fires in the wait cycle that brings the count to TO_CYCLES.
    always_comb begin
        w_nxt = r_state;
        w_to  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (R0_REQ && R1_REQ)
                    w_nxt = r_last ? ST_G0 : ST_G1;
                else if (R0_REQ)
                    w_nxt = ST_G0;
                else if (R1_REQ)
                    w_nxt = ST_G1;
            end
            ST_G0: begin
                w_to = !SCx_nWAIT && (r_wcnt == TO_M1);
                if (w_to || (!R0_REQ && !R0_LOCK && SCx_nWAIT))
                    w_nxt = R1_REQ ? ST_G1 : ST_IDLE;
            end
            ST_G1: begin
                w_to = !SCx_nWAIT && (r_wcnt == TO_M1);
                if (w_to || (!R1_REQ && !R1_LOCK && SCx_nWAIT))
                    w_nxt = R0_REQ ? ST_G0 : ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    assign w_g0 = (r_state == ST_G0);
    assign w_g1 = (r_state == ST_G1);
    assign GNT  = r_state;

    always_comb begin
        SCx_REQ    = 1'b0;
        SCx_WT     = 1'b0;
        SCx_BE     = 4'd0;
        SCx_ADDR   = 32'd0;
        SCx_WDT    = 39'd0;
        R0_nWAIT   = 1'b0;
        R0_FAULT   = 1'b0;
        R0_TimeOut = 1'b0;
        R0_RDT     = 39'd0;
        R1_nWAIT   = 1'b0;
        R1_FAULT   = 1'b0;
        R1_TimeOut = 1'b0;
        R1_RDT     = 39'd0;
        unique case (1'b1)
            w_g0: begin
                SCx_REQ    = R0_REQ && !w_to;
                SCx_WT     = R0_WT;
                SCx_BE     = R0_BE;
                SCx_ADDR   = R0_ADDR;
                SCx_WDT    = R0_WDT;
                R0_nWAIT   = SCx_nWAIT;
                R0_FAULT   = SCx_FAULT || w_to;
                R0_TimeOut = w_to;
                R0_RDT     = SCx_RDT;
            end
            w_g1: begin
                SCx_REQ    = R1_REQ && !w_to;
                SCx_WT     = R1_WT;
                SCx_BE     = R1_BE;
                SCx_ADDR   = R1_ADDR;
                SCx_WDT    = R1_WDT;
                R1_nWAIT   = SCx_nWAIT;
                R1_FAULT   = SCx_FAULT || w_to;
                R1_TimeOut = w_to;
                R1_RDT     = SCx_RDT;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scx_arb.sv
// Directed bench for scx_arb: collision, lock burst, timeout,
// read pass-through and asynchronous reset.
module tb_scx_arb;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        R0_REQ, R0_LOCK, R0_WT;
    logic [3:0]  R0_BE;
    logic [31:0] R0_ADDR;
    logic [38:0] R0_WDT;
    logic        R0_nWAIT, R0_FAULT, R0_TimeOut;
    logic [38:0] R0_RDT;
    logic        R1_REQ, R1_LOCK, R1_WT;
    logic [3:0]  R1_BE;
    logic [31:0] R1_ADDR;
    logic [38:0] R1_WDT;
    logic        R1_nWAIT, R1_FAULT, R1_TimeOut;
    logic [38:0] R1_RDT;
    logic        SCx_REQ, SCx_WT;
    logic [3:0]  SCx_BE;
    logic [31:0] SCx_ADDR;
    logic [38:0] SCx_WDT;
    logic        SCx_nWAIT, SCx_FAULT;
    logic [38:0] SCx_RDT;
    logic [1:0]  GNT;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    scx_arb #(.TO_CYCLES(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .R0_REQ(R0_REQ), .R0_LOCK(R0_LOCK), .R0_WT(R0_WT),
        .R0_BE(R0_BE), .R0_ADDR(R0_ADDR), .R0_WDT(R0_WDT),
        .R0_nWAIT(R0_nWAIT), .R0_FAULT(R0_FAULT),
        .R0_TimeOut(R0_TimeOut), .R0_RDT(R0_RDT),
        .R1_REQ(R1_REQ), .R1_LOCK(R1_LOCK), .R1_WT(R1_WT),
        .R1_BE(R1_BE), .R1_ADDR(R1_ADDR), .R1_WDT(R1_WDT),
        .R1_nWAIT(R1_nWAIT), .R1_FAULT(R1_FAULT),
        .R1_TimeOut(R1_TimeOut), .R1_RDT(R1_RDT),
        .SCx_REQ(SCx_REQ), .SCx_WT(SCx_WT), .SCx_BE(SCx_BE),
        .SCx_ADDR(SCx_ADDR), .SCx_WDT(SCx_WDT),
        .SCx_nWAIT(SCx_nWAIT), .SCx_FAULT(SCx_FAULT),
        .SCx_RDT(SCx_RDT), .GNT(GNT)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        R0_REQ = 0; R0_LOCK = 0; R0_WT = 0; R0_BE = 0;
        R0_ADDR = 0; R0_WDT = 0;
        R1_REQ = 0; R1_LOCK = 0; R1_WT = 0; R1_BE = 0;
        R1_ADDR = 0; R1_WDT = 0;
        SCx_nWAIT = 1; SCx_FAULT = 0; SCx_RDT = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        R0_REQ = 1; R1_REQ = 1;
        SCx_RDT = 39'h55_0000_00AA;
        step();
        checks++;
        if (GNT !== 2'b00) begin
            errors++; $display("FAIL rst_gnt got %b exp 00", GNT);
        end
        checks++;
        if (SCx_REQ !== 1'b0) begin
            errors++; $display("FAIL rst_screq got %b exp 0", SCx_REQ);
        end
        checks++;
        if (R0_nWAIT !== 1'b0 || R1_nWAIT !== 1'b0) begin
            errors++;
            $display("FAIL rst_nwait got %b%b exp 00", R0_nWAIT, R1_nWAIT);
        end
        checks++;
        if (R1_RDT !== 39'd0) begin
            errors++; $display("FAIL rst_rdt got %h exp 0", R1_RDT);
        end
        idle_inputs();
        step();
        nRST = 1;
        step();
    endtask

    task automatic test_collision();
        R0_REQ = 1; R1_REQ = 1;
        R0_ADDR = 32'hA0; R1_ADDR = 32'hB0;
        #1;
        checks++;
        if (GNT !== 2'b00 || SCx_REQ !== 1'b0) begin
            errors++;
            $display("FAIL col_latency got gnt=%b req=%b exp 00/0", GNT, SCx_REQ);
        end
        step();
        checks++;
        if (GNT !== 2'b01) begin
            errors++; $display("FAIL col_first got %b exp 01", GNT);
        end
        checks++;
        if (SCx_REQ !== 1'b1 || SCx_ADDR !== 32'hA0) begin
            errors++;
            $display("FAIL col_mux0 got req=%b addr=%h exp 1/a0", SCx_REQ, SCx_ADDR);
        end
        checks++;
        if (R0_nWAIT !== 1'b1 || R1_nWAIT !== 1'b0) begin
            errors++;
            $display("FAIL col_nwait got %b%b exp 10", R0_nWAIT, R1_nWAIT);
        end
        R0_REQ = 0;
        step();
        checks++;
        if (GNT !== 2'b10 || SCx_ADDR !== 32'hB0) begin
            errors++;
            $display("FAIL col_handover got gnt=%b addr=%h exp 10/b0", GNT, SCx_ADDR);
        end
        R1_REQ = 0;
        step();
        checks++;
        if (GNT !== 2'b00) begin
            errors++; $display("FAIL col_idle got %b exp 00", GNT);
        end
    endtask

    task automatic test_burst_lock();
        R1_REQ = 1; R1_LOCK = 1; R1_WT = 1; R1_BE = 4'hF;
        R1_ADDR = 32'h100;
        step();
        R0_REQ = 1;
        for (int i = 0; i < 4; i++) begin
            R1_ADDR = 32'h100 + 32'(4 * i);
            R1_WDT = 39'(i + 1);
            #1;
            checks++;
            if (GNT !== 2'b10 || SCx_ADDR !== 32'h100 + 32'(4 * i)
                || SCx_WT !== 1'b1 || SCx_WDT !== 39'(i + 1)) begin
                errors++;
                $display("FAIL burst_beat%0d got gnt=%b addr=%h wt=%b wdt=%h",
                         i, GNT, SCx_ADDR, SCx_WT, SCx_WDT);
            end
            step();
        end
        R1_REQ = 0;
        #1;
        checks++;
        if (GNT !== 2'b10 || SCx_REQ !== 1'b0) begin
            errors++;
            $display("FAIL burst_gap got gnt=%b req=%b exp 10/0", GNT, SCx_REQ);
        end
        step();
        checks++;
        if (GNT !== 2'b10) begin
            errors++; $display("FAIL burst_hold got %b exp 10", GNT);
        end
        R1_LOCK = 0; R1_WT = 0;
        step();
        checks++;
        if (GNT !== 2'b01) begin
            errors++; $display("FAIL burst_release got %b exp 01", GNT);
        end
        R0_REQ = 0;
        step();
        idle_inputs();
    endtask

    task automatic test_timeout();
        R0_REQ = 1; SCx_nWAIT = 0; R0_ADDR = 32'hC0;
        step();
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (GNT !== 2'b01 || R0_TimeOut !== 1'b0 || SCx_REQ !== 1'b1) begin
                errors++;
                $display("FAIL to_wait%0d got gnt=%b to=%b req=%b exp 01/0/1",
                         i, GNT, R0_TimeOut, SCx_REQ);
            end
            step();
        end
        checks++;
        if (R0_TimeOut !== 1'b1 || R0_FAULT !== 1'b1) begin
            errors++;
            $display("FAIL to_fire got to=%b fault=%b exp 1/1", R0_TimeOut, R0_FAULT);
        end
        checks++;
        if (SCx_REQ !== 1'b0 || GNT !== 2'b01 || R1_TimeOut !== 1'b0) begin
            errors++;
            $display("FAIL to_squash got req=%b gnt=%b to1=%b exp 0/01/0",
                     SCx_REQ, GNT, R1_TimeOut);
        end
        R0_REQ = 0;
        step();
        checks++;
        if (GNT !== 2'b00 || R0_TimeOut !== 1'b0 || R0_FAULT !== 1'b0) begin
            errors++;
            $display("FAIL to_after got gnt=%b to=%b fault=%b exp 00/0/0",
                     GNT, R0_TimeOut, R0_FAULT);
        end
        idle_inputs();
    endtask

    task automatic test_read();
        R1_REQ = 1; R1_WT = 0; R1_ADDR = 32'h200;
        SCx_RDT = 39'h12_3456_789A;
        step();
        checks++;
        if (GNT !== 2'b10 || R1_RDT !== 39'h12_3456_789A || R1_nWAIT !== 1'b1) begin
            errors++;
            $display("FAIL rd_r1 got gnt=%b rdt=%h nw=%b", GNT, R1_RDT, R1_nWAIT);
        end
        checks++;
        if (R0_RDT !== 39'd0 || R0_nWAIT !== 1'b0) begin
            errors++;
            $display("FAIL rd_r0 got rdt=%h nw=%b exp 0/0", R0_RDT, R0_nWAIT);
        end
        SCx_FAULT = 1;
        #1;
        checks++;
        if (R1_FAULT !== 1'b1 || R1_TimeOut !== 1'b0 || R0_FAULT !== 1'b0) begin
            errors++;
            $display("FAIL rd_fault got f1=%b to1=%b f0=%b exp 1/0/0",
                     R1_FAULT, R1_TimeOut, R0_FAULT);
        end
        step();
        SCx_FAULT = 0;
        checks++;
        if (GNT !== 2'b10) begin
            errors++; $display("FAIL rd_keep got %b exp 10", GNT);
        end
        R1_REQ = 0;
        step();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        R0_REQ = 1; R0_LOCK = 1; R0_WT = 1;
        step();
        checks++;
        if (GNT !== 2'b01) begin
            errors++; $display("FAIL ar_pre got %b exp 01", GNT);
        end
        #2;
        nRST = 0;
        #1;
        checks++;
        if (GNT !== 2'b00 || SCx_REQ !== 1'b0 || R0_nWAIT !== 1'b0) begin
            errors++;
            $display("FAIL ar_now got gnt=%b req=%b nw=%b exp 00/0/0",
                     GNT, SCx_REQ, R0_nWAIT);
        end
        idle_inputs();
        step();
        #3;
        nRST = 1;
        step();
        R0_REQ = 1; R1_REQ = 1;
        step();
        checks++;
        if (GNT !== 2'b01) begin
            errors++; $display("FAIL ar_restart got %b exp 01", GNT);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_collision();
        test_burst_lock();
        test_timeout();
        test_read();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
